main_memory_responder: RTL and testbench
========================================

// Module: main_memory_responder
// PURPOSE
//  Memory-side responder for the core's load/store and fetch traffic: accepts one request per valid/ready
//  handshake, models WAIT_CYCLES of access latency, then returns read data or a write acknowledge.
//  Sits between core memory control and a word-addressed storage array; enables multi-cycle memory.
// PARAMETERS
//  DEPTH        2048  storage words, power of two; index = addr[$clog2(DEPTH)-1:0]
//  WAIT_CYCLES  2     cycles spent in WAIT before response, 0..15; 0 = respond cycle after accept
// PORTS
//  clk        in   1   clock, all state on posedge
//  rst        in   1   asynchronous, active-low reset
//  req_valid  in   1   request present
//  req_ready  out  1   responder can accept a request
//  req_write  in   1   1 = write, 0 = read
//  req_addr   in   32  word address
//  req_wdata  in   32  write data
//  rsp_valid  out  1   response present, held until taken
//  rsp_ready  in   1   requester takes response
//  rsp_rdata  out  32  read data (0 for writes and errors)
//  rsp_err    out  1   address >= DEPTH; access suppressed
//  rd_count   out  32  accepted reads      (MEM_ACCESS_COUNT_EN only)
//  wr_count   out  32  accepted writes     (MEM_ACCESS_COUNT_EN only)
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait count 0,
//    counters 0. Storage contents are not reset. A request in flight is dropped, no response issued.
//  - FSM IDLE -> WAIT -> RESP -> IDLE (RESP -> IDLE only on rsp_ready).
//  - IDLE: req_ready=1. On req_valid: latch write/addr/wdata, load wait count = WAIT_CYCLES, go WAIT
//    (WAIT_CYCLES=0: go straight to RESP, access performed on the accept edge).
//  - WAIT: req_ready=0. Count decrements each cycle. When it reaches 0, go RESP; storage access
//    on that same edge. Write commits mem[idx]<=wdata. Read registers rsp_rdata<=mem[idx].
//  - Latency: accept edge to rsp_valid high = WAIT_CYCLES+1 cycles.
//  - RESP: rsp_valid=1; rsp_rdata/rsp_err stable until handshake. On rsp_ready, go IDLE and drop
//    rsp_valid. rsp_rdata is cleared to 0 on the same edge.
//  - No back-to-back in one cycle: the request after a response is accepted no earlier than the cycle
//    after the rsp_ready edge. req_ready is never high while rsp_valid=1.
//  - Error: addr[31:$clog2(DEPTH)] != 0 -> no write, rsp_rdata=0, rsp_err=1. Latency unchanged.
//  - req_valid in WAIT/RESP is ignored, not queued. The requester holds the request until req_ready.
//  - Read-after-write to the same address in the next transaction returns the new data.
// CONFIGURATION
//  - `MEM_ACCESS_COUNT_EN defined: rd_count/wr_count ports exist. Each increments by 1 on every accepted
//    request of its type, including errored ones, and wraps 2^32-1 -> 0.
//  - Not defined: ports and counter flops absent. All other behaviour is identical.
// STRUCTURE
//  - arch_defines.v: MEM_RSP_STATE_IDLE=2'd0, MEM_RSP_STATE_WAIT=2'd1, MEM_RSP_STATE_RESP=2'd2 and
//    MEM_RSP_STATE_WIDTH=2.
//  - One sub-module: mem_wait_counter (4-bit loadable down-counter with zero flag, async active-low reset).
//  - Storage is an inline reg array in this module; no separate memory module is instantiated.
// TESTING
//  - Reset: drive rst=0 mid-WAIT -> req_ready=1, rsp_valid=0 same cycle; no response after release.
//  - Write/read: WAIT_CYCLES=2. Write addr 5 data 32'hDEADBEEF -> rsp_valid on 3rd edge after accept,
//    rsp_err=0. Then read addr 5 -> rsp_rdata=32'hDEADBEEF, 3 cycles after accept.
//  - Backpressure: hold rsp_ready=0 for 10 cycles -> rsp_valid and data stable, req_ready=0 throughout.
//    New req_valid during this time is not accepted.
//  - Out of range: DEPTH=2048, read addr 2048 -> rsp_err=1, rsp_rdata=0. Write addr 4096 -> rsp_err=1,
//    mem[0] unchanged.
//  - Zero latency: WAIT_CYCLES=0, read addr 0 -> rsp_valid the cycle after accept.
//  - Counters (MEM_ACCESS_COUNT_EN): 3 reads + 2 writes (one errored) -> rd_count=3, wr_count=2.

Source files
------------

// File: rtl/main_memory_responder_pkg.sv
// Shared types for the memory responder: FSM state encoding, latched request record, range check.
// Pure declarations; no logic, no latency, no flow control.
package main_memory_responder_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } rsp_state_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    // Any address bit above the storage index makes the access an error.
    function automatic logic addr_out_of_range(input logic [ADDR_W-1:0] addr, input int idx_w);
        return (addr >> idx_w) != '0;
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// 4-bit loadable down-counter; zero_nxt flags that the count is zero after this edge.
// Latency: load/decrement take effect on the next edge. No flow control.
// Backpressure: none; the owner decides when to load or decrement.
module mem_wait_counter
    import main_memory_responder_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_val,
    input  logic              dec,
    output logic              zero_nxt
);

    logic [WAIT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    assign zero_nxt = (count_d == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/main_memory_responder.sv
// Word-addressed memory responder: one request per handshake, WAIT_CYCLES+1 cycles to response.
// Backpressure: response held until rsp_ready; req_ready low outside IDLE, requests are not queued.
// Optional `MEM_ACCESS_COUNT_EN adds rd_count/wr_count accepted-request counters.
module main_memory_responder
    import main_memory_responder_pkg::*;
#(
    parameter int DEPTH       = 2048,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
`ifdef MEM_ACCESS_COUNT_EN
    ,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
`endif
);

    localparam int IDX_W = $clog2(DEPTH);

    rsp_state_e        state_q, state_d;
    mem_req_t          req_q, req_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic [DATA_W-1:0] mem [DEPTH];

    mem_req_t          acc;
    logic              acc_err;
    logic [IDX_W-1:0]  acc_idx;
    logic              access;
    logic              mem_we;
    logic              accept;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_zero_nxt;

    mem_wait_counter u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (WAIT_W'(WAIT_CYCLES)),
        .dec      (cnt_dec),
        .zero_nxt (cnt_zero_nxt)
    );

    // With zero wait the access happens on the accept edge, straight from the request inputs.
    always_comb begin
        acc = req_q;
        if (state_q == ST_IDLE) begin
            acc.write = req_write;
            acc.addr  = req_addr;
            acc.wdata = req_wdata;
        end
    end

    assign acc_err = addr_out_of_range(acc.addr, IDX_W);
    assign acc_idx = acc.addr[IDX_W-1:0];
    assign accept  = (state_q == ST_IDLE) && req_valid;

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        access      = 1'b0;
        mem_we      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    req_d.write = req_write;
                    req_d.addr  = req_addr;
                    req_d.wdata = req_wdata;
                    if (WAIT_CYCLES == 0) begin
                        access  = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        cnt_load = 1'b1;
                        state_d  = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_dec = 1'b1;
                if (cnt_zero_nxt) begin
                    access  = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (access) begin
            rsp_err_d   = acc_err;
            rsp_rdata_d = (acc.write || acc_err) ? '0 : mem[acc_idx];
            mem_we      = rst && acc.write && !acc_err;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Storage contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[acc_idx] <= acc.wdata;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

`ifdef MEM_ACCESS_COUNT_EN
    logic [31:0] rd_count_q, rd_count_d;
    logic [31:0] wr_count_q, wr_count_d;

    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (accept) begin
            if (req_write) begin
                wr_count_d = wr_count_q + 32'd1;
            end else begin
                rd_count_d = rd_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed bench: instance 0 uses WAIT_CYCLES=2, instance 1 uses WAIT_CYCLES=0.
module tb_main_memory_responder;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        req_write;
    logic [1:0][31:0]  req_addr;
    logic [1:0][31:0]  req_wdata;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [1:0][31:0]  rsp_rdata;
    logic [1:0]        rsp_err;
`ifdef MEM_ACCESS_COUNT_EN
    logic [1:0][31:0]  rd_count;
    logic [1:0][31:0]  wr_count;
`endif

    int checks = 0;
    int errors = 0;
    int exp_rd [2] = '{0, 0};
    int exp_wr [2] = '{0, 0};

    always #5 clk = ~clk;

    main_memory_responder #(.DEPTH(2048), .WAIT_CYCLES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid[0]),
        .req_ready (req_ready[0]),
        .req_write (req_write[0]),
        .req_addr  (req_addr[0]),
        .req_wdata (req_wdata[0]),
        .rsp_valid (rsp_valid[0]),
        .rsp_ready (rsp_ready[0]),
        .rsp_rdata (rsp_rdata[0]),
        .rsp_err   (rsp_err[0])
`ifdef MEM_ACCESS_COUNT_EN
        ,
        .rd_count  (rd_count[0]),
        .wr_count  (wr_count[0])
`endif
    );

    main_memory_responder #(.DEPTH(2048), .WAIT_CYCLES(0)) dut_z (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid[1]),
        .req_ready (req_ready[1]),
        .req_write (req_write[1]),
        .req_addr  (req_addr[1]),
        .req_wdata (req_wdata[1]),
        .rsp_valid (rsp_valid[1]),
        .rsp_ready (rsp_ready[1]),
        .rsp_rdata (rsp_rdata[1]),
        .rsp_err   (rsp_err[1])
`ifdef MEM_ACCESS_COUNT_EN
        ,
        .rd_count  (rd_count[1]),
        .wr_count  (wr_count[1])
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues one request and returns the accept-to-rsp_valid latency in cycles.
    task automatic send(input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, output int lat);
        int n;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_addr[d]  = addr;
        req_wdata[d] = data;
        n = 0;
        while (!req_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[d]) check("accept_timeout", {31'd0, req_ready[d]}, 32'd1);
        @(negedge clk);
        req_valid[d] = 1'b0;
        if (wr) exp_wr[d]++;
        else    exp_rd[d]++;
        lat = 1;
        while (!rsp_valid[d] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take(input int d);
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        check("post_take_vld", {31'd0, rsp_valid[d]}, 32'd0);
        check("post_take_rdata", rsp_rdata[d], 32'd0);
    endtask

    initial begin
        int lat;
        int bad_dat;
        int bad_rdy;
        int seen;

        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = '0;

        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready[0]}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata[0], 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err[0]}, 32'd0);
        rst = 1'b1;

        // Reset asserted while a write is in WAIT.
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 32'd7;
        req_wdata[0] = 32'h1234_5678;
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("wait_req_ready", {31'd0, req_ready[0]}, 32'd0);
        rst = 1'b0;
        #1;
        check("midrst_req_ready", {31'd0, req_ready[0]}, 32'd1);
        check("midrst_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid[0]) seen++;
        end
        check("no_rsp_after_rst", seen, 32'd0);

        // Write then read back.
        send(0, 1'b1, 32'd5, 32'hDEAD_BEEF, lat);
        check("wr_latency", lat, 32'd3);
        check("wr_err", {31'd0, rsp_err[0]}, 32'd0);
        check("wr_rdata", rsp_rdata[0], 32'd0);
        check("resp_req_ready", {31'd0, req_ready[0]}, 32'd0);
        take(0);
        send(0, 1'b0, 32'd5, 32'd0, lat);
        check("rd_latency", lat, 32'd3);
        check("rd_rdata", rsp_rdata[0], 32'hDEAD_BEEF);
        check("rd_err", {31'd0, rsp_err[0]}, 32'd0);

        // Hold the response; a competing write must be ignored.
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 32'd5;
        req_wdata[0] = 32'd0;
        bad_dat = 0;
        bad_rdy = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'hDEAD_BEEF || rsp_err[0] !== 1'b0) bad_dat++;
            if (req_ready[0] !== 1'b0) bad_rdy++;
        end
        check("bp_stable", bad_dat, 32'd0);
        check("bp_req_ready", bad_rdy, 32'd0);
        req_valid[0] = 1'b0;
        take(0);
        send(0, 1'b0, 32'd5, 32'd0, lat);
        check("bp_ignored_wr", rsp_rdata[0], 32'hDEAD_BEEF);
        take(0);

        // Out-of-range accesses.
        send(0, 1'b1, 32'd0, 32'h1111_1111, lat);
        take(0);
        send(0, 1'b0, 32'd2048, 32'd0, lat);
        check("oor_rd_latency", lat, 32'd3);
        check("oor_rd_err", {31'd0, rsp_err[0]}, 32'd1);
        check("oor_rd_rdata", rsp_rdata[0], 32'd0);
        take(0);
        send(0, 1'b1, 32'd4096, 32'h2222_2222, lat);
        check("oor_wr_err", {31'd0, rsp_err[0]}, 32'd1);
        take(0);
        send(0, 1'b0, 32'd0, 32'd0, lat);
        check("mem0_kept", rsp_rdata[0], 32'h1111_1111);
        check("mem0_err", {31'd0, rsp_err[0]}, 32'd0);
        take(0);

        // Zero-wait instance.
        send(1, 1'b1, 32'd0, 32'hA5A5_A5A5, lat);
        check("z_wr_latency", lat, 32'd1);
        take(1);
        send(1, 1'b0, 32'd0, 32'd0, lat);
        check("z_rd_latency", lat, 32'd1);
        check("z_rd_rdata", rsp_rdata[1], 32'hA5A5_A5A5);
        take(1);

`ifdef MEM_ACCESS_COUNT_EN
        check("rd_count", rd_count[0], exp_rd[0]);
        check("wr_count", wr_count[0], exp_wr[0]);
        check("z_rd_count", rd_count[1], exp_rd[1]);
        check("z_wr_count", wr_count[1], exp_wr[1]);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
